// File: rtl/apb_target_sram_pkg.sv
// Shared APB target types: request/response structs, target FSM states, wait-count width.
package apb_target_sram_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef struct packed {
    logic [31:0] paddr;
    logic        penable;
    logic        psel;
    logic        pwrite;
    logic [31:0] pwdata;
  } t_apb_request;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        perr;
  } t_apb_response;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} t_apb_target_state;

  // Index width that still works for a single-word memory.
  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/apb_target_sram_mem.sv
// Single-port synchronous SRAM, 32-bit words; rdata is registered and held until the next read.
module apb_target_sram_mem #(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = 10
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[index] <= wdata;
    if (rd_en) rdata <= mem[index];
  end

endmodule

// File: rtl/apb_target_sram.sv
// APB3 completer in front of a single-port SRAM with programmable wait states.
// Define APB_TARGET_SRAM_PERR_EN to report out-of-range accesses on perr.
module apb_target_sram
  import apb_target_sram_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset,
  input  logic [31:0] apb_request__paddr,
  input  logic        apb_request__penable,
  input  logic        apb_request__psel,
  input  logic        apb_request__pwrite,
  input  logic [31:0] apb_request__pwdata,
  output logic [31:0] apb_response__prdata,
  output logic        apb_response__pready,
  output logic        apb_response__perr
);

  localparam int IDX_W = idx_w(MEM_WORDS);

  t_apb_request  req;
  t_apb_response rsp;

  assign req = '{paddr:   apb_request__paddr,
                 penable: apb_request__penable,
                 psel:    apb_request__psel,
                 pwrite:  apb_request__pwrite,
                 pwdata:  apb_request__pwdata};

  t_apb_target_state     state, state_nxt;
  logic [WAIT_CNT_W-1:0] cnt, cnt_nxt;
  logic                  pready_q, pready_nxt;
  logic                  lat_wr, lat_wr_nxt;
  logic                  lat_ok, lat_ok_nxt;

  logic [29:0] word;
  logic        in_range, setup;
  logic        rd_en, wr_en;
  logic [31:0] rdata;
  logic        unused_addr_lsb;

  assign word            = req.paddr[31:2];
  assign unused_addr_lsb = ^req.paddr[1:0];
  assign in_range        = ({2'b00, word} < 32'(MEM_WORDS));
  assign setup           = (state == IDLE) && req.psel && !req.penable;

  // Out-of-range accesses never touch the SRAM; reset wins over a coincident setup.
  assign wr_en = clk__enable && !reset && setup && in_range &&  req.pwrite;
  assign rd_en = clk__enable && !reset && setup && in_range && !req.pwrite;

  apb_target_sram_mem #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) u_mem (
    .clk   (clk),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .index (word[IDX_W-1:0]),
    .wdata (req.pwdata),
    .rdata (rdata)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pready_nxt = pready_q;
    lat_wr_nxt = lat_wr;
    lat_ok_nxt = lat_ok;
    case (state)
      IDLE: if (setup) begin
        lat_wr_nxt = req.pwrite;
        lat_ok_nxt = in_range;
        if (WAIT_STATES == 0) begin
          state_nxt  = DONE;
          pready_nxt = 1'b1;
        end else begin
          cnt_nxt   = WAIT_CNT_W'(WAIT_STATES);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!req.psel) begin
          state_nxt = IDLE;
        end else if (cnt == WAIT_CNT_W'(1)) begin
          state_nxt  = DONE;
          pready_nxt = 1'b1;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: if (!req.psel || req.penable) begin
        state_nxt  = IDLE;
        pready_nxt = 1'b0;
      end
      default: begin
        state_nxt  = IDLE;
        pready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk__enable) begin
      if (reset) begin
        state    <= IDLE;
        cnt      <= '0;
        pready_q <= 1'b0;
        lat_wr   <= 1'b0;
        lat_ok   <= 1'b0;
      end else begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        pready_q <= pready_nxt;
        lat_wr   <= lat_wr_nxt;
        lat_ok   <= lat_ok_nxt;
      end
    end
  end

  always_comb begin
    rsp        = '0;
    rsp.pready = pready_q;
    rsp.prdata = (pready_q && !lat_wr && lat_ok) ? rdata : 32'h0;
`ifdef APB_TARGET_SRAM_PERR_EN
    rsp.perr   = pready_q && !lat_ok;
`else
    rsp.perr   = 1'b0;
`endif
  end

  assign apb_response__prdata = rsp.prdata;
  assign apb_response__pready = rsp.pready;
  assign apb_response__perr   = rsp.perr;

endmodule

// File: tb/tb_apb_target_sram.sv
// Bench for apb_target_sram: three instances (different wait states / sizes), table vectors,
// hand-written corner sequences and randomized traffic against a word-array reference model.
module tb_apb_target_sram;

  localparam int ND = 3;
  localparam int WS [ND] = '{0, 3, 5};
  localparam int MW [ND] = '{1024, 1000, 1024};
`ifdef APB_TARGET_SRAM_PERR_EN
  localparam bit PERR = 1'b1;
`else
  localparam bit PERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        ce, reset;
  logic [31:0] paddr  [ND];
  logic        penable[ND];
  logic        psel   [ND];
  logic        pwrite [ND];
  logic [31:0] pwdata [ND];
  logic [31:0] prdata [ND];
  logic        pready [ND];
  logic        perr   [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    apb_target_sram #(.MEM_WORDS(MW[g]), .WAIT_STATES(WS[g])) u_dut (
      .clk                  (clk),
      .clk__enable          (ce),
      .reset                (reset),
      .apb_request__paddr   (paddr[g]),
      .apb_request__penable (penable[g]),
      .apb_request__psel    (psel[g]),
      .apb_request__pwrite  (pwrite[g]),
      .apb_request__pwdata  (pwdata[g]),
      .apb_response__prdata (prdata[g]),
      .apb_response__pready (pready[g]),
      .apb_response__perr   (perr[g])
    );
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [longint];

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint key(input int d, input logic [31:0] addr);
    return (longint'(d) << 32) | longint'(addr[31:2]);
  endfunction

  function automatic bit in_rng(input int d, input logic [31:0] addr);
    return longint'(addr[31:2]) < longint'(MW[d]);
  endfunction

  // One full APB transfer; returns data/err sampled in the completing cycle and access-cycle count.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output bit err, output int cyc);
    bit bad_pre = 1'b0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    cyc = 1;
    while (!pready[d] && cyc <= 40) begin
      if (prdata[d] !== 32'h0 || perr[d] !== 1'b0) bad_pre = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    rd  = prdata[d];
    err = perr[d];
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk("quiet_before_pready", 32'(bad_pre), 32'h0);
    chk("pready_single_cycle", 32'(pready[d]), 32'h0);
  endtask

  task automatic apply(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input bit exp_err, input string name);
    logic [31:0] rd;
    bit          err;
    int          cyc;
    xfer(d, wr, addr, wd, rd, err, cyc);
    chk({name, "_latency"}, 32'(cyc), 32'(WS[d] + 1));
    chk({name, "_prdata"}, rd, exp_rd);
    chk({name, "_perr"}, 32'(err), 32'(exp_err));
    if (wr && in_rng(d, addr)) mdl[key(d, addr)] = wd;
  endtask

  task automatic model_op(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] exp_rd;
    exp_rd = (!wr && in_rng(d, addr)) ? mdl[key(d, addr)] : 32'h0;
    apply(d, wr, addr, wd, exp_rd, PERR && !in_rng(d, addr), "rand");
  endtask

  vec_t vecs[$];

  initial begin
    bit saw;
    logic [31:0] a;
    int          n_ce;

    ce = 1'b1; reset = 1'b1;
    for (int i = 0; i < ND; i++) begin
      paddr[i] = '0; penable[i] = 1'b0; psel[i] = 1'b0; pwrite[i] = 1'b0; pwdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      chk("reset_pready", 32'(pready[i]), 32'h0);
      chk("reset_perr",   32'(perr[i]),   32'h0);
      chk("reset_prdata", prdata[i],      32'h0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    vecs.push_back('{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0,         1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0,         PERR});
    vecs.push_back('{0, 1'b0, 32'h0000_1000, 32'h0,         32'h0,         PERR});
    vecs.push_back('{0, 1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h8000_0010, 32'h0,         32'h0,         PERR});
    vecs.push_back('{1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h0000_0F9C, 32'hA5A5_A5A5, 32'h0,         1'b0});
    vecs.push_back('{1, 1'b0, 32'h0000_0F9C, 32'h0,         32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h0000_0FA0, 32'h1111_1111, 32'h0,         PERR});
    vecs.push_back('{1, 1'b0, 32'h0000_0FA0, 32'h0,         32'h0,         PERR});
    vecs.push_back('{2, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0,         1'b0});
    vecs.push_back('{2, 1'b0, 32'h0000_0020, 32'h0,         32'h0BAD_F00D, 1'b0});
    foreach (vecs[i])
      apply(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err,
            $sformatf("vec%0d", i));

    // Back-to-back: read setup in the cycle right after write completion.
    apply(0, 1'b1, 32'h4, 32'h1, 32'h0, 1'b0, "b2b_wr");
    apply(0, 1'b0, 32'h4, 32'h0, 32'h1, 1'b0, "b2b_rd");

    // penable without a setup phase is ignored.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'h10;
    saw = 1'b0;
    repeat (3) begin @(posedge clk); #1; saw |= pready[0]; end
    psel[0] = 1'b0; penable[0] = 1'b0;
    chk("penable_in_idle", 32'(saw), 32'h0);
    @(posedge clk); #1;

    // Abort: psel dropped in the 2nd wait cycle.
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b0; paddr[2] = 32'h20;
    @(posedge clk); #1;
    penable[2] = 1'b1; saw = pready[2];
    @(posedge clk); #1;
    saw |= pready[2];
    psel[2] = 1'b0; penable[2] = 1'b0;
    repeat (8) begin @(posedge clk); #1; saw |= pready[2]; end
    chk("abort_no_pready", 32'(saw), 32'h0);
    apply(2, 1'b0, 32'h20, 32'h0, 32'h0BAD_F00D, 1'b0, "after_abort");

    // Reset during WAIT of a write; the write was committed at setup.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h8; pwdata[1] = 32'h55;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_mid_pready", 32'(pready[1]), 32'h0);
    reset = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    saw = 1'b0;
    repeat (5) begin @(posedge clk); #1; saw |= pready[1]; end
    chk("reset_mid_idle", 32'(saw), 32'h0);
    mdl[key(1, 32'h8)] = 32'h55;
    apply(1, 1'b0, 32'h8, 32'h0, 32'h55, 1'b0, "after_reset");

    // Clock enable low for 3 edges in WAIT stretches the transfer by exactly 3 edges.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h10;
    @(posedge clk); #1;
    penable[1] = 1'b1; ce = 1'b0; saw = 1'b0;
    repeat (3) begin @(posedge clk); #1; saw |= pready[1]; end
    ce = 1'b1;
    n_ce = 0;
    while (!pready[1] && n_ce < 20) begin @(posedge clk); #1; n_ce++; end
    chk("ce_hold_pready", 32'(saw), 32'h0);
    chk("ce_resume_edges", 32'(n_ce), 32'(WS[1]));
    chk("ce_prdata", prdata[1], 32'hCAFE_F00D);
    @(posedge clk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    chk("ce_done", 32'(pready[1]), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 80; i++) begin
      int d, r, idx;
      d = $urandom_range(0, ND - 1);
      r = $urandom_range(0, 9);
      idx = 256 + $urandom_range(0, 15);
      a = 32'(idx * 4) | 32'($urandom_range(0, 3));
      if (r >= 8) begin
        a = 32'((MW[d] + $urandom_range(0, 100)) * 4);
        if (r == 9) a = $urandom | 32'h8000_0000;
        model_op(d, $urandom_range(0, 1) == 1, a, $urandom);
      end else if (r < 4 || !mdl.exists(key(d, a))) begin
        model_op(d, 1'b1, a, $urandom);
      end else begin
        model_op(d, 1'b0, a, 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
